// File: rtl/bus_interconnect.sv
// bus_interconnect: round-robin multi-master to multi-slave shared bus.
// Optional no-ready timeout is built when the BUS_TIMEOUT_EN macro is defined.
//
// Handshake: the owning master drives m_as_=0 to start a transfer and holds it,
// together with address/rw/write data, until it sees m_rdy_=0 in that same
// cycle. The selected slave answers by driving its s_rdy_ bit low for one
// cycle; m_err=1 alongside m_rdy_=0 marks a timed-out (failed) transfer.
module bus_interconnect #(
    parameter int MASTER_CH   = 4,
    parameter int SLAVE_CH    = 8,
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [MASTER_CH-1:0]          m_req_,
    output logic [MASTER_CH-1:0]          m_grnt_,
    input  logic [MASTER_CH*ADDR_W-1:0]   m_addr,
    input  logic [MASTER_CH-1:0]          m_as_,
    input  logic [MASTER_CH-1:0]          m_rw,
    input  logic [MASTER_CH*DATA_W-1:0]   m_wr_data,
    output logic [DATA_W-1:0]             m_rd_data,
    output logic                          m_rdy_,
    output logic                          m_err,
    output logic [ADDR_W-1:0]             s_addr,
    output logic                          s_as_,
    output logic                          s_rw,
    output logic [DATA_W-1:0]             s_wr_data,
    output logic [SLAVE_CH-1:0]           s_cs_,
    input  logic [SLAVE_CH*DATA_W-1:0]    s_rd_data,
    input  logic [SLAVE_CH-1:0]           s_rdy_
);

    localparam int OW = (MASTER_CH > 1) ? $clog2(MASTER_CH) : 1;
    localparam int SW = (SLAVE_CH > 1) ? $clog2(SLAVE_CH) : 1;

    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     cand;
    logic              found;
    logic [SW-1:0]     slv_idx;
    logic [DATA_W-1:0] sel_rd_data;
    logic              sel_rdy_;

    // Next owner: hold while the owner requests, else first requester after it.
    always_comb begin
        owner_d = owner_q;
        found   = 1'b0;
        cand    = owner_q;
        if (m_req_[owner_q]) begin
            for (int i = 1; i <= MASTER_CH; i++) begin
                cand = OW'((int'(owner_q) + i) % MASTER_CH);
                if (!found && !m_req_[cand]) begin
                    owner_d = cand;
                    found   = 1'b1;
                end
            end
        end
    end

    // Owner register; reset overrides any arbitration decision.
    always_ff @(posedge clk) begin
        if (reset) owner_q <= '0;
        else       owner_q <= owner_d;
    end

    // Grant decode and master-to-slave mux, both from the registered owner only.
    always_comb begin
        m_grnt_   = '1;
        s_addr    = '0;
        s_as_     = 1'b1;
        s_rw      = 1'b0;
        s_wr_data = '0;
        for (int i = 0; i < MASTER_CH; i++) begin
            if (owner_q == OW'(i)) begin
                m_grnt_[i] = 1'b0;
                s_addr     = m_addr[i*ADDR_W +: ADDR_W];
                s_as_      = m_as_[i];
                s_rw       = m_rw[i];
                s_wr_data  = m_wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Slave decode from the top address bits; unmapped indices select nothing.
    always_comb begin
        slv_idx     = s_addr[ADDR_W-1 -: SW];
        s_cs_       = '1;
        sel_rd_data = '0;
        sel_rdy_    = 1'b1;
        for (int i = 0; i < SLAVE_CH; i++) begin
            if (!s_as_ && slv_idx == SW'(i)) begin
                s_cs_[i]    = 1'b0;
                sel_rd_data = s_rd_data[i*DATA_W +: DATA_W];
                sel_rdy_    = s_rdy_[i];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_fire;

    // Count unanswered strobe cycles; a genuine ready in the firing cycle wins.
    always_comb begin
        tmo_fire = !s_as_ && sel_rdy_ && (tmo_q == TW'(TIMEOUT_CYC));
        if (s_as_ || !sel_rdy_ || tmo_fire) tmo_d = '0;
        else                                tmo_d = tmo_q + 1'b1;
        m_rdy_    = sel_rdy_ & ~tmo_fire;
        m_err     = tmo_fire;
        m_rd_data = tmo_fire ? '0 : sel_rd_data;
    end

    // Timeout counter register; reset abandons any in-flight count.
    always_ff @(posedge clk) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    // No timeout: the selected slave's response passes straight through.
    always_comb begin
        m_rdy_    = sel_rdy_;
        m_err     = 1'b0;
        m_rd_data = sel_rd_data;
    end
`endif

endmodule

// File: doc/bus_interconnect.md
BUS_INTERCONNECT -- requirements
Module: bus_interconnect

Interface
REQ-001 Parameter MASTER_CH, default 4, SHALL set the number of bus masters (2..8).
REQ-002 Parameter SLAVE_CH, default 8, SHALL set the number of slaves (2..16).
REQ-003 Parameter ADDR_W, default 30, SHALL set the word-address width.
REQ-004 Parameter DATA_W, default 32, SHALL set the data width.
REQ-005 Parameter TIMEOUT_CYC, default 16, SHALL set the no-ready timeout length in cycles (>=2).
REQ-006 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-008 m_req_  in  MASTER_CH  SHALL carry the per-master bus request, active low.
REQ-009 m_grnt_  out  MASTER_CH  SHALL carry the per-master grant, active low, one-hot-low.
REQ-010 m_addr  in  MASTER_CH*ADDR_W  SHALL carry the packed master addresses, master i at bits [i*ADDR_W +: ADDR_W].
REQ-011 m_as_, m_rw  in  MASTER_CH each  SHALL carry address strobe (active low) and read(1)/write(0).
REQ-012 m_wr_data  in  MASTER_CH*DATA_W  SHALL carry packed master write data.
REQ-013 m_rd_data  out  DATA_W; m_rdy_  out  1; m_err  out  1  SHALL return read data, ready (active low) and error to the owning master.
REQ-014 s_addr  out  ADDR_W; s_as_  out  1; s_rw  out  1; s_wr_data  out  DATA_W  SHALL drive the shared slave-side bus.
REQ-015 s_cs_  out  SLAVE_CH  SHALL carry per-slave chip select, active low.
REQ-016 s_rd_data  in  SLAVE_CH*DATA_W; s_rdy_  in  SLAVE_CH  SHALL carry packed slave read data and ready (active low).

Function
REQ-017 Ownership SHALL be held in a registered owner index; m_grnt_ SHALL be decoded from it only (no combinational path from m_req_).
REQ-018 While the owner holds m_req_=0, ownership SHALL NOT change, regardless of other requests.
REQ-019 When the owner has m_req_=1, the next owner SHALL be the first requester in round-robin order starting at owner+1 (wrapping), taking effect at the next edge (1-cycle grant latency).
REQ-020 With no requests at all, ownership SHALL remain with the current owner (parked).
REQ-021 s_addr, s_as_, s_rw, s_wr_data SHALL be combinationally muxed from the owner's signals.
REQ-022 Slave index SHALL be s_addr[ADDR_W-1 -: clog2(SLAVE_CH)]; s_cs_[idx]=0 only while s_as_=0 and idx<SLAVE_CH; all other s_cs_ bits =1.
REQ-023 m_rd_data/m_rdy_ SHALL follow the selected slave combinationally; with no slave selected, m_rd_data=0 and m_rdy_=1.
REQ-024 An index >= SLAVE_CH (unmapped) SHALL assert no chip select.

Reset
REQ-025 On reset=1 at an edge, owner SHALL become 0, so m_grnt_ = all ones except bit 0 = 0 from the following cycle.
REQ-026 Reset SHALL clear the timeout counter to 0 and m_err to 0; a transfer in flight SHALL be abandoned with no error pulse.
REQ-027 A reset asserted concurrently with a release/request SHALL take priority over arbitration.

Configuration
REQ-028 Macro BUS_TIMEOUT_EN defined: a counter SHALL increment each cycle s_as_=0 and the selected m_rdy_=1, clear when s_as_=1, a ready is returned, or on the cycle after an error; when it equals TIMEOUT_CYC, that cycle SHALL drive m_rdy_=0, m_err=1, m_rd_data=0.
REQ-029 Timeout SHALL cover unmapped addresses; a real slave ready in the same cycle as the count reaching TIMEOUT_CYC SHALL win (m_err=0).
REQ-030 Macro undefined: no counter SHALL be built, m_err SHALL be tied 0, and an unanswered strobe SHALL wait indefinitely.

Verification
REQ-031 Reset, no requests -> m_grnt_=4'b1110, all s_cs_=1, m_rdy_=1, m_err=0.
REQ-032 Owner 0 releases; masters 1 and 3 request same cycle -> next cycle m_grnt_=4'b1101; master 1 releases -> m_grnt_=4'b0111 one cycle later.
REQ-033 Owner 2 holds req_ 10 cycles while masters 0,1,3 request -> grant stays 4'b1011 throughout.
REQ-034 Owner reads s_addr with index 5, slave 5 returns 32'hDEADBEEF with s_rdy_[5]=0 after 3 cycles -> s_cs_=8'b11011111, m_rd_data=32'hDEADBEEF, m_rdy_=0 on that cycle.
REQ-035 BUS_TIMEOUT_EN, TIMEOUT_CYC=4, strobe to silent slave from cycle 0 -> cycle 4 m_rdy_=0, m_err=1, m_rd_data=0; cycle 5 counter=0.
REQ-036 Reset asserted on cycle 2 of a timed-out access -> no m_err pulse, m_grnt_=4'b1110 next cycle.
